// File: rtl/ss_engine_sched_pkg.sv
// ============================================================================
// ss_sched_pkg : shared constants for the DMA engine-bank scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package ss_sched_pkg;

  localparam int DC_W = 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Engine-select bits inside the descriptor control word
  localparam int DC_RBHASH = 8;
  localparam int DC_COPY   = 9;
  localparam int DC_FILL   = 10;

  localparam logic [1:0] RST_STATE  = S_IDLE;
  localparam logic       RST_ENABLE = 1'b0;
  localparam logic       RST_BUSY   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/ss_rr_arbiter.sv
// ============================================================================
// ss_rr_arbiter : combinational round-robin pick, first requester at/after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module ss_rr_arbiter #(
  parameter int NCH = 2,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  idx,
  output logic           valid
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = PW'((int'(ptr) + k) % NCH);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ss_engine_sched.sv
// ============================================================================
// ss_engine_sched : round-robin job sequencer for the copy/fill/hash engines
// Optional per-channel statistics behind SCHED_STATS_EN.     Rev 1.0
// ============================================================================
`default_nettype none

module ss_engine_sched #(
  parameter int NCH       = 2,
  parameter int DC_W      = ss_sched_pkg::DC_W,
  parameter int TMO_W     = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH*DC_W-1:0] ch_dc,
  output logic [NCH-1:0]      ch_gnt,
  output logic [NCH-1:0]      ch_done,
  output logic [NCH-1:0]      ch_err,
  input  logic [TMO_W-1:0]    tmo_limit,
  output logic [DC_W-1:0]     dc,
  output logic                m_enable,
  input  logic                m_endn,
  output logic                busy
`ifdef SCHED_STATS_EN
  ,
  output logic [NCH*16-1:0]   stat_jobs,
  output logic [NCH*8-1:0]    stat_tmo
`endif
);

  import ss_sched_pkg::*;

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW = $clog2(FLUSH_CYC + 1);

  logic [1:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    g_idx;
  logic [TMO_W-1:0] wd;
  logic [FW-1:0]    fcnt;
  logic             job_err;

  logic [NCH-1:0]   arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_valid;
  logic [DC_W-1:0]  sel_dc;
  logic             end_seen;
  logic             wd_hit;

  ss_rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .req   (ch_req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_dc   = ch_dc[int'(arb_idx)*DC_W +: DC_W];
  // wd==0 marks the first RUN cycle, where m_endn may still be undriven
  assign end_seen = (wd != '0) && !m_endn;
  assign wd_hit   = (tmo_limit != '0) && (wd == tmo_limit - TMO_W'(1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= RST_STATE;
      rr_ptr   <= '0;
      g_idx    <= '0;
      wd       <= '0;
      fcnt     <= '0;
      job_err  <= 1'b0;
      ch_gnt   <= '0;
      ch_done  <= '0;
      ch_err   <= '0;
      dc       <= '0;
      m_enable <= RST_ENABLE;
      busy     <= RST_BUSY;
    end else begin
      ch_done <= '0;
      ch_err  <= '0;
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            ch_gnt <= arb_gnt;
            g_idx  <= arb_idx;
            dc     <= sel_dc;
            busy   <= 1'b1;
            state  <= S_START;
          end
        end
        S_START: begin
          if (dc == '0) begin
            job_err <= 1'b1;
            fcnt    <= '0;
            state   <= S_FLUSH;
          end else begin
            m_enable <= 1'b1;
            wd       <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (wd != '1) begin
            wd <= wd + TMO_W'(1);
          end
          if (end_seen) begin
            m_enable <= 1'b0;
            job_err  <= 1'b0;
            fcnt     <= '0;
            state    <= S_FLUSH;
          end else if (wd_hit) begin
            m_enable <= 1'b0;
            job_err  <= 1'b1;
            fcnt     <= '0;
            state    <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (fcnt == FW'(FLUSH_CYC - 1)) begin
            dc     <= '0;
            ch_gnt <= '0;
            if (job_err) ch_err[g_idx]  <= 1'b1;
            else         ch_done[g_idx] <= 1'b1;
            rr_ptr <= (int'(g_idx) == NCH - 1) ? '0 : g_idx + PW'(1);
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  for (genvar i = 0; i < NCH; i++) begin : g_stats
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        stat_jobs[i*16 +: 16] <= '0;
        stat_tmo[i*8 +: 8]    <= '0;
      end else begin
        if (ch_done[i] && (stat_jobs[i*16 +: 16] != 16'hFFFF)) begin
          stat_jobs[i*16 +: 16] <= stat_jobs[i*16 +: 16] + 16'd1;
        end
        if (ch_err[i] && (stat_tmo[i*8 +: 8] != 8'hFF)) begin
          stat_tmo[i*8 +: 8] <= stat_tmo[i*8 +: 8] + 8'd1;
        end
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ss_engine_sched.sv
// ============================================================================
// tb_ss_engine_sched : self-checking bench for ss_engine_sched (2 channels)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ss_engine_sched;

  localparam int NCH = 2;
  localparam int FC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ch_req = '0;
  logic [47:0] ch_dc = '0;
  logic [1:0]  ch_gnt, ch_done, ch_err;
  logic [15:0] tmo_limit = '0;
  logic [23:0] dc;
  logic        m_enable;
  logic        m_endn = 1'b0;
  logic        busy;
`ifdef SCHED_STATS_EN
  logic [31:0] stat_jobs;
  logic [15:0] stat_tmo;
`endif

  ss_engine_sched #(.NCH(NCH), .DC_W(24), .TMO_W(16), .FLUSH_CYC(FC)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .ch_req    (ch_req),
    .ch_dc     (ch_dc),
    .ch_gnt    (ch_gnt),
    .ch_done   (ch_done),
    .ch_err    (ch_err),
    .tmo_limit (tmo_limit),
    .dc        (dc),
    .m_enable  (m_enable),
    .m_endn    (m_endn),
    .busy      (busy)
`ifdef SCHED_STATS_EN
    ,
    .stat_jobs (stat_jobs),
    .stat_tmo  (stat_tmo)
`endif
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    end_after_cfg = 0;
  int    en_cnt = 0;
  int    mptr = 0;
  int    last_p = -1;
  string ctx = "init";

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: junk-low m_endn whenever not enabled and in the first enabled
  // cycle; pulls low once, end_after_cfg cycles after enable (0 = never).
  always @(negedge clk) begin
    if (!m_enable) begin
      en_cnt = 0;
      m_endn = 1'b0;
    end else begin
      m_endn = (en_cnt == 0 || (end_after_cfg >= 1 && en_cnt == end_after_cfg)) ? 1'b0 : 1'b1;
      en_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", ctx, nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] m, input int p);
    for (int k = 0; k < NCH; k++) begin
      if (m[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  // Job outcome from the rules: ends only from the 2nd enabled cycle, end beats
  // a same-cycle timeout, a zero descriptor is always an error.
  function automatic bit model_ok(input logic [23:0] d, input int ea, input int tmo);
    return (d != 0) && (ea >= 1) && (tmo == 0 || ea + 1 <= tmo);
  endfunction

  task automatic run_job(input int exp_ch, input bit exp_ok, input logic [1:0] mask,
                         input logic [23:0] d0, input logic [23:0] d1,
                         input int end_after, input int tmo, input bit drop, input bit gap_chk);
    logic [23:0] exp_dc;
    bit          zero;
    bit          dc_held;
    int          exp_w, n_g, n_e, n_off, n_p;
    logic [1:0]  pd, pe;
    exp_dc = (exp_ch == 0) ? d0 : d1;
    zero   = (exp_dc == 0);
    exp_w  = exp_ok ? end_after + 1 : tmo;
    ch_req = mask;
    ch_dc  = {d1, d0};
    tmo_limit = tmo[15:0];
    end_after_cfg = end_after;
    n_g = -1;
    for (int i = 0; i < 20 && n_g < 0; i++) begin
      @(negedge clk);
      if (ch_gnt != 0) n_g = cyc;
    end
    chk("grant_seen", int'(n_g >= 0), 1);
    if (n_g < 0) return;
    chk("gnt", ch_gnt, 1 << exp_ch);
    chk("dc_latch", dc, exp_dc);
    chk("busy_on", busy, 1);
    if (gap_chk) chk("idle_gap", n_g - last_p, 1);
    if (drop) ch_req = '0;
    ch_dc = ~{d1, d0};
    n_e = -1; n_off = -1; n_p = -1; dc_held = 1'b1; pd = '0; pe = '0;
    for (int i = 0; i < tmo + end_after + 40 && n_p < 0; i++) begin
      @(negedge clk);
      if (m_enable && n_e < 0) n_e = cyc;
      if (!m_enable && n_e >= 0 && n_off < 0) n_off = cyc;
      if ((ch_done | ch_err) != 0) begin
        n_p = cyc; pd = ch_done; pe = ch_err;
      end else if (dc != exp_dc || ch_gnt != (2'b01 << exp_ch)) begin
        dc_held = 1'b0;
      end
    end
    chk("pulse_seen", int'(n_p >= 0), 1);
    if (n_p < 0) return;
    chk("dc_gnt_held", dc_held, 1);
    chk("done", pd, exp_ok ? (1 << exp_ch) : 0);
    chk("err", pe, exp_ok ? 0 : (1 << exp_ch));
    chk("dc_clr", dc, 0);
    chk("gnt_clr", ch_gnt, 0);
    chk("busy_off", busy, 0);
    if (zero) begin
      chk("zero_no_en", n_e, -1);
      chk("zero_lat", n_p - n_g, FC + 1);
    end else begin
      chk("en_lat", n_e - n_g, 1);
      chk("en_width", n_off - n_e, exp_w);
      chk("flush_len", n_p - n_off, FC);
    end
    last_p = n_p;
    mptr = (exp_ch + 1) % NCH;
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [23:0] d0;
    logic [23:0] d1;
    int          end_after;
    int          tmo;
    int          exp_ch;
    bit          exp_ok;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int bad, ng, ch, ea, tm;
    logic [1:0]  mk;
    logic [23:0] r0, r1;

    tbl[0] = '{2'b01, 24'h000100, 24'h000000, 40, 0,   0, 1'b1};
    tbl[1] = '{2'b10, 24'h000000, 24'h000200, 5,  100, 1, 1'b1};
    tbl[2] = '{2'b11, 24'h000300, 24'h000500, 3,  0,   0, 1'b1};
    tbl[3] = '{2'b11, 24'h000300, 24'h000500, 2,  0,   1, 1'b1};
    tbl[4] = '{2'b01, 24'h000400, 24'h000000, 0,  100, 0, 1'b0};
    tbl[5] = '{2'b01, 24'h000100, 24'h000000, 19, 20,  0, 1'b1};
    tbl[6] = '{2'b10, 24'h000100, 24'h000000, 0,  0,   1, 1'b0};
    tbl[7] = '{2'b11, 24'h000100, 24'h000600, 1,  0,   0, 1'b1};
    tbl[8] = '{2'b01, 24'h000700, 24'h000000, 20, 20,  0, 1'b0};
    tbl[9] = '{2'b11, 24'h000100, 24'h000900, 5,  1,   1, 1'b0};

    ctx = "reset";
    repeat (3) @(negedge clk);
    chk("rst_gnt", ch_gnt, 0);
    chk("rst_dc", dc, 0);
    chk("rst_en", m_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", ch_done | ch_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ctx = $sformatf("tbl%0d", i);
      run_job(tbl[i].exp_ch, tbl[i].exp_ok, tbl[i].mask, tbl[i].d0, tbl[i].d1,
              tbl[i].end_after, tbl[i].tmo, 1'b1, i != 0);
    end

    // Continuous two-channel request: strict alternation with 1-cycle gaps
    for (int j = 0; j < 4; j++) begin
      ctx = $sformatf("rr%0d", j);
      run_job(j % 2, 1'b1, 2'b11, 24'h000100, 24'h000200, 4, 0, j == 3, 1'b1);
    end

    // Leave the pointer at 1, then start a job that never ends with no watchdog
    ctx = "long";
    run_job(0, 1'b1, 2'b01, 24'h000100, 24'h000000, 3, 0, 1'b1, 1'b1);
    ch_req = 2'b10;
    ch_dc  = {24'h000800, 24'h000000};
    tmo_limit = '0;
    end_after_cfg = 0;
    ng = -1;
    for (int i = 0; i < 20 && ng < 0; i++) begin
      @(negedge clk);
      if (ch_gnt != 0) ng = cyc;
    end
    chk("long_gnt", ch_gnt, 2);
    ch_req = '0;
    bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (!m_enable || (ch_done | ch_err) != 0) bad++;
    end
    chk("no_abort", bad, 0);

    // Asynchronous reset in the middle of the hung job
    ctx = "midrst";
    #3;
    rst = 1'b1;
    ch_req = 2'b11;
    ch_dc  = {24'h000200, 24'h000100};
    #1;
    chk("gnt", ch_gnt, 0);
    chk("dc", dc, 0);
    chk("en", m_enable, 0);
    chk("busy", busy, 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ((ch_done | ch_err | ch_gnt) != 0) bad++;
    end
    chk("no_pulse", bad, 0);
    rst = 1'b0;
    mptr = 0;
    run_job(0, 1'b1, 2'b11, 24'h000100, 24'h000200, 10, 0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ctx = $sformatf("rnd%0d", i);
      mk = 2'($urandom_range(1, 3));
      r0 = ($urandom_range(0, 5) == 0) ? 24'h0 : 24'($urandom());
      r1 = ($urandom_range(0, 5) == 0) ? 24'h0 : 24'($urandom());
      tm = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
      ea = int'($urandom_range(0, 30));
      if (tm == 0 && ea == 0) ea = 1;
      ch = pick(mk, mptr);
      run_job(ch, model_ok((ch == 0) ? r0 : r1, ea, tm), mk, r0, r1, ea, tm, 1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ss_engine_sched.md
Name: ss_engine_sched

Overview:
- Sequences the DMA engine datapath (copy/fill/rabin-hash engines sharing the m_src/m_dst FIFO bus) between NCH descriptor channels.
- Round-robin grants one channel and drives its 24-bit descriptor control word onto the engines' `dc` bus. Asserts `m_enable`, waits for the engine's active-low `m_endn`, then flushes and releases the bus.
- A per-job watchdog aborts hung jobs. Sits between the descriptor fetch units and the engine bank.

Parameters:
- NCH, 2, number of requesting channels (2..8).
- DC_W, 24, descriptor control word width.
- TMO_W, 16, watchdog counter width.
- FLUSH_CYC, 2, cycles `dc` is held after `m_enable` drops, so the engine's trailing put/length word completes.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- ch_req  in  NCH  per-channel job request (level).
- ch_dc  in  NCH*DC_W  per-channel control word; channel i uses bits [i*DC_W +: DC_W].
- ch_gnt  out  NCH  one-hot grant; held for the whole job.
- ch_done  out  NCH  1-cycle pulse on normal completion.
- ch_err  out  NCH  1-cycle pulse on watchdog abort.
- tmo_limit  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
- dc  out  DC_W  control word to the engine bank; all-zero when idle, which releases the tristate bus.
- m_enable  out  1  engine enable/resetn.
- m_endn  in  1  engine end, active-low; X/Z when no engine is selected.
- busy  out  1  high in any state except S_IDLE.

Behaviour:
- Reset values: ch_gnt=0, ch_done=0, ch_err=0, dc=0, m_enable=0, busy=0, state=S_IDLE, rr pointer=0, watchdog=0.
- Reset is honoured mid-job: all outputs return to reset values asynchronously and the job is lost with no done/err pulse.
- All outputs are registered.
- S_IDLE: if any ch_req is set, pick the first requester at or after the rr pointer (wrapping). Register ch_gnt, latch that channel's ch_dc into the dc register, go to S_START. Latency from req to gnt/dc is 1 cycle.
- S_START: one cycle with dc valid and m_enable=0, so the engine sees a stable select before enable. Next cycle m_enable=1, go to S_RUN.
- S_RUN: watchdog increments every cycle. `m_endn` is sampled only in S_RUN and only from the second cycle of S_RUN onward; earlier values (possibly X) are ignored.
  - If m_endn==0: m_enable<=0, go to S_FLUSH(ok).
  - Else if tmo_limit!=0 and watchdog==tmo_limit-1: m_enable<=0, go to S_FLUSH(err).
  - If end and timeout occur in the same cycle, end wins and the job counts as ok.
  - The watchdog saturates and does not wrap.
- S_FLUSH: dc held for FLUSH_CYC cycles with m_enable=0. Then dc<=0, ch_gnt<=0, and a pulse on ch_done[g] (ok) or ch_err[g] (err). Advance the rr pointer to g+1 mod NCH. Go to S_IDLE.
- Back-to-back: the next grant can be issued in the cycle after the done pulse, so the minimum idle gap is 1 cycle.
- Request handling:
  - ch_req dropped during a job is ignored; the job runs to completion.
  - ch_dc changes after the grant are ignored because dc is latched.
  - The granted channel must drop ch_req on ch_done/ch_err. If it is still high in S_IDLE it is treated as a new job.
- Latched dc==0 (no engine selected): go straight to S_FLUSH(err), so the job can never hang.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Enabled: adds output stat_jobs (NCH*16) and stat_tmo (NCH*8).
  - stat_jobs: per-channel count of completed jobs, incremented with ch_done.
  - stat_tmo: per-channel count of timeouts, incremented with ch_err.
  - Both counters saturate and reset to 0.
- Disabled: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ss_sched_pkg holds:
  - State encoding: S_IDLE, S_START, S_RUN, S_FLUSH.
  - DC_W.
  - Engine-select bit positions (DC_COPY, DC_FILL, DC_RBHASH=8).
  - Reset constants.
- Sub-module ss_rr_arbiter (NCH requests plus pointer in, one-hot grant and index out, combinational). It is reused by other engine-bank schedulers.

Test Plan:
- Single job: ch_req=01, ch_dc[0]=24'h000100, engine pulls m_endn low 40 cycles after enable -> dc=24'h000100 one cycle after req, m_enable rises one cycle later, ch_done[0] pulses FLUSH_CYC+1 cycles after m_endn low, then dc=0.
- Round-robin: ch_req=11 held continuously for 4 jobs -> grant order 0,1,0,1 with a 1-cycle idle gap between jobs.
- Watchdog: tmo_limit=100, m_endn never low -> m_enable drops 100 cycles after rising, ch_err[0] pulses, no ch_done. With tmo_limit=0 and 5000 idle cycles -> no abort.
- Tie: m_endn goes low in the same cycle the watchdog hits the limit -> ch_done pulse, ch_err stays 0.
- Mid-job reset: assert wb_rst_i during S_RUN -> all outputs 0 immediately, no pulses. After release, a pending req is granted normally with the rr pointer at 0.
- Zero descriptor: ch_dc=0 granted -> ch_err pulse within FLUSH_CYC+2 cycles, m_enable never asserted.
